// File: rtl/lsu_bus_master.sv
// lsu_bus_master
// Load/store initiator sitting between the core memory stage and the data RAM bus.
// Takes one command at a time, screens it for alignment, size code and address
// window, then holds a request on the bus until grant or timeout and reports the
// outcome with a single done pulse. Load data is sign/zero-extended here, so the
// bus-side uload strobe is always driven high during a transfer.

module lsu_bus_master #(
   parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
   parameter int unsigned RAM_BYTES = 4096,
   parameter int unsigned TIMEOUT   = 15
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_we_i,
   input  logic [31:0] cmd_addr_i,
   input  logic [31:0] cmd_wdata_i,
   input  logic [1:0]  cmd_hb_i,
   input  logic        cmd_uload_i,
   output logic        done_o,
   output logic [1:0]  err_o,
   output logic [31:0] rdata_o,
   output logic        req_o,
   output logic        ce_o,
   input  logic        gnt_i,
   output logic [31:0] addr_o,
   output logic [31:0] wdata_o,
   output logic        we_o,
   output logic [1:0]  hb_o,
   output logic        uload_o,
   input  logic [31:0] rdata_i
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_ALIGN   = 2'b01;
   localparam logic [1:0] ERR_RANGE   = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   localparam int unsigned    TW          = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]  TIMER_LAST  = TW'(TIMEOUT - 1);
   localparam logic [31:0]    RAM_BYTES_W = 32'(RAM_BYTES);

   logic [1:0]    r_state;
   logic [TW-1:0] r_timer;
   logic [31:0]   r_addr;
   logic [31:0]   r_wdata;
   logic          r_we;
   logic [1:0]    r_hb;
   logic          r_uload;
   logic          r_busUload;
   logic [1:0]    r_err;
   logic [31:0]   r_rdata;

   logic          w_misaligned;
   logic          w_inWindow;
   logic          w_badSize;
   logic [32:0]   w_offset;
   logic [31:0]   w_loadExt;

   // Screen the incoming command; the 33-bit offset keeps the window test safe
   // against wrap-around when the window sits at the top of the address map.
   always_comb begin
      w_misaligned = ((cmd_hb_i == 2'b10) && (cmd_addr_i[1:0] != 2'b00)) ||
                     ((cmd_hb_i == 2'b01) && cmd_addr_i[0]);
      w_offset     = {1'b0, cmd_addr_i} - {1'b0, RAM_BASE};
      w_inWindow   = !w_offset[32] && (w_offset[31:0] < RAM_BYTES_W);
      w_badSize    = (cmd_hb_i == 2'b11) || !w_inWindow;
   end

   // Extend right-aligned bus read data according to the latched size and uload.
   always_comb begin
      w_loadExt = rdata_i;
      case (r_hb)
         2'b00:   w_loadExt = r_uload ? {24'b0, rdata_i[7:0]}
                                      : {{24{rdata_i[7]}}, rdata_i[7:0]};
         2'b01:   w_loadExt = r_uload ? {16'b0, rdata_i[15:0]}
                                      : {{16{rdata_i[15]}}, rdata_i[15:0]};
         default: w_loadExt = rdata_i;
      endcase
   end

   // Main control: accept and screen in IDLE, wait for grant or timeout in REQ,
   // then spend exactly one cycle in FIN to present the result.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_timer    <= '0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_we       <= 1'b0;
         r_hb       <= 2'b00;
         r_uload    <= 1'b0;
         r_busUload <= 1'b0;
         r_err      <= ERR_OK;
         r_rdata    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cmd_valid_i) begin
                  r_addr  <= cmd_addr_i;
                  r_wdata <= cmd_wdata_i;
                  r_we    <= cmd_we_i;
                  r_hb    <= cmd_hb_i;
                  r_uload <= cmd_uload_i;
                  r_timer <= '0;
                  r_rdata <= '0;
                  if (w_misaligned) begin
                     r_err   <= ERR_ALIGN;
                     r_state <= S_FIN;
                  end else if (w_badSize) begin
                     r_err   <= ERR_RANGE;
                     r_state <= S_FIN;
                  end else begin
                     r_err      <= ERR_OK;
                     r_busUload <= 1'b1;
                     r_state    <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (gnt_i) begin
                  r_err   <= ERR_OK;
                  r_rdata <= r_we ? 32'h0 : w_loadExt;
                  r_state <= S_FIN;
               end else if (r_timer == TIMER_LAST) begin
                  r_err   <= ERR_TIMEOUT;
                  r_rdata <= '0;
                  r_state <= S_FIN;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            S_FIN: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Handshake and bus strobes are decoded straight from the state register, so
   // the request drops on the edge that samples the grant or the timeout.
   always_comb begin
      cmd_ready_o = (r_state == S_IDLE);
      done_o      = (r_state == S_FIN);
      err_o       = done_o ? r_err : 2'b00;
      rdata_o     = done_o ? r_rdata : 32'h0;
      req_o       = (r_state == S_REQ);
      ce_o        = (r_state == S_REQ);
      we_o        = (r_state == S_REQ) && r_we;
      addr_o      = r_addr;
      wdata_o     = r_wdata;
      hb_o        = r_hb;
      uload_o     = r_busUload;
   end

endmodule

// File: tb/tb_lsu_bus_master.sv
// tb_lsu_bus_master
// Directed bench for the load/store bus master. A small responder grants after a
// programmable number of request cycles; expected done results go into a
// scoreboard queue when each command is issued and are popped on done_o.

module tb_lsu_bus_master;

   typedef struct packed {
      logic [1:0]  err;
      logic [31:0] rdata;
   } exp_t;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic        cmd_we_i = 1'b0;
   logic [31:0] cmd_addr_i = '0;
   logic [31:0] cmd_wdata_i = '0;
   logic [1:0]  cmd_hb_i = 2'b00;
   logic        cmd_uload_i = 1'b0;
   logic        done_o;
   logic [1:0]  err_o;
   logic [31:0] rdata_o;
   logic        req_o;
   logic        ce_o;
   logic        gnt_i = 1'b0;
   logic [31:0] addr_o;
   logic [31:0] wdata_o;
   logic        we_o;
   logic [1:0]  hb_o;
   logic        uload_o;
   logic [31:0] rdata_i = '0;

   int   compared   = 0;
   int   mismatched = 0;
   int   cycle      = 0;
   int   doneCount  = 0;
   int   doneCycle  = 0;
   int   acceptCycle = 0;
   int   gntAfter   = 1;
   logic [31:0] respData = '0;
   int   burstLen   = 0;
   int   lastBurstLen = 0;
   int   burstsSeen = 0;
   logic [31:0] lastAddr  = '0;
   logic [31:0] lastWdata = '0;
   logic [1:0]  lastHb    = 2'b00;
   logic        lastWe    = 1'b0;
   logic        lastUload = 1'b0;
   exp_t        sbQueue[$];
   exp_t        monExp;

   lsu_bus_master dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_we_i    (cmd_we_i),
      .cmd_addr_i  (cmd_addr_i),
      .cmd_wdata_i (cmd_wdata_i),
      .cmd_hb_i    (cmd_hb_i),
      .cmd_uload_i (cmd_uload_i),
      .done_o      (done_o),
      .err_o       (err_o),
      .rdata_o     (rdata_o),
      .req_o       (req_o),
      .ce_o        (ce_o),
      .gnt_i       (gnt_i),
      .addr_o      (addr_o),
      .wdata_o     (wdata_o),
      .we_o        (we_o),
      .hb_o        (hb_o),
      .uload_o     (uload_o),
      .rdata_i     (rdata_i)
   );

   // 10 ns clock.
   always #5 clk_i = ~clk_i;

   // Free-running cycle counter used for latency measurements.
   always @(posedge clk_i) cycle++;

   // Responder: counts request cycles, grants on the programmed cycle (0 = never),
   // snapshots the bus fields and records each finished request burst.
   always @(posedge clk_i) begin
      #1;
      if (req_o) begin
         burstLen++;
         lastAddr  = addr_o;
         lastWdata = wdata_o;
         lastHb    = hb_o;
         lastWe    = we_o;
         lastUload = uload_o;
         gnt_i     = (gntAfter != 0) && (burstLen == gntAfter);
         rdata_i   = respData;
      end else begin
         gnt_i = 1'b0;
         if (burstLen != 0) begin
            lastBurstLen = burstLen;
            burstsSeen++;
            burstLen = 0;
         end
      end
   end

   // Scoreboard consumer: every done pulse must match the oldest expectation.
   always @(negedge clk_i) begin
      if (done_o) begin
         doneCount++;
         doneCycle = cycle;
         if (sbQueue.size() == 0) begin
            checkOutput("scoreboardDepth", 32'(sbQueue.size()), 32'd1);
         end else begin
            monExp = sbQueue.pop_front();
            checkOutput("err", 32'(err_o), 32'(monExp.err));
            checkOutput("rdata", rdata_o, monExp.rdata);
         end
      end
   end

   // Hard stop in case something wedges the sequence.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Issue one command once the master is ready; optionally queue its expected
   // result and wait (bounded) for exactly one done pulse.
   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] hb, input logic uload,
                                input logic [1:0] expErr, input logic [31:0] expRdata,
                                input bit expectDone);
      int k;
      int startDone;
      k = 0;
      @(negedge clk_i);
      while (!cmd_ready_o && k < 50) begin
         @(negedge clk_i);
         k++;
      end
      checkOutput("cmdReady", 32'(cmd_ready_o), 32'd1);
      if (expectDone) sbQueue.push_back(exp_t'{err: expErr, rdata: expRdata});
      startDone   = doneCount;
      cmd_we_i    = we;
      cmd_addr_i  = addr;
      cmd_wdata_i = wdata;
      cmd_hb_i    = hb;
      cmd_uload_i = uload;
      cmd_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      acceptCycle = cycle;
      cmd_valid_i = 1'b0;
      if (expectDone) begin
         k = 0;
         while (doneCount == startDone && k < 60) begin
            @(posedge clk_i);
            k++;
         end
         #1;
         checkOutput("doneCount", 32'(doneCount - startDone), 32'd1);
      end
   endtask

   // Directed sequence.
   initial begin
      int bs;
      int dc;
      $display("[TB] start");

      // Reset state.
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      checkOutput("rstReady", 32'(cmd_ready_o), 32'd1);
      checkOutput("rstReq", 32'(req_o), 32'd0);
      checkOutput("rstCe", 32'(ce_o), 32'd0);
      checkOutput("rstDone", 32'(done_o), 32'd0);
      checkOutput("rstErr", 32'(err_o), 32'd0);
      checkOutput("rstRdata", rdata_o, 32'd0);
      checkOutput("rstAddr", addr_o, 32'd0);
      checkOutput("rstWdata", wdata_o, 32'd0);
      checkOutput("rstWeHb", {29'd0, we_o, hb_o}, 32'd0);
      checkOutput("rstUload", 32'(uload_o), 32'd0);
      rst_i = 1'b0;

      // lw @0x10, grant on third request cycle.
      gntAfter = 3;
      respData = 32'h8899AABB;
      bs = burstsSeen;
      applyStimulus(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 2'b00, 32'h8899AABB, 1'b1);
      checkOutput("lwBurstLen", 32'(lastBurstLen), 32'd3);
      checkOutput("lwBursts", 32'(burstsSeen - bs), 32'd1);
      checkOutput("lwLatency", 32'(doneCycle - acceptCycle), 32'd3);
      checkOutput("lwAddr", lastAddr, 32'h10);

      // Byte and half loads with both extension modes.
      gntAfter = 1;
      respData = 32'h000000F0;
      applyStimulus(1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 2'b00, 32'hFFFFFFF0, 1'b1);
      checkOutput("lbBusUload", 32'(lastUload), 32'd1);
      applyStimulus(1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 2'b00, 32'h000000F0, 1'b1);
      respData = 32'h00008001;
      applyStimulus(1'b0, 32'h20, 32'h0, 2'b01, 1'b1, 2'b00, 32'h00008001, 1'b1);
      applyStimulus(1'b0, 32'h20, 32'h0, 2'b01, 1'b0, 2'b00, 32'hFFFF8001, 1'b1);

      // sh @0x22: bus fields observed while requesting.
      gntAfter = 2;
      respData = 32'hFFFFFFFF;
      applyStimulus(1'b1, 32'h22, 32'h1234ABCD, 2'b01, 1'b0, 2'b00, 32'h0, 1'b1);
      checkOutput("shAddr", lastAddr, 32'h22);
      checkOutput("shHb", 32'(lastHb), 32'd1);
      checkOutput("shWe", 32'(lastWe), 32'd1);
      checkOutput("shWdata", lastWdata, 32'h1234ABCD);

      // Local errors: no bus request, done the cycle after accept.
      bs = burstsSeen;
      applyStimulus(1'b0, 32'h6, 32'h0, 2'b10, 1'b0, 2'b01, 32'h0, 1'b1);
      checkOutput("misLatency", 32'(doneCycle - acceptCycle), 32'd0);
      applyStimulus(1'b0, 32'h4, 32'h0, 2'b11, 1'b0, 2'b10, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'h1000, 32'h0, 2'b10, 1'b0, 2'b10, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'h1001, 32'h0, 2'b01, 1'b0, 2'b01, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'hFFC, 32'h0, 2'b10, 1'b0, 2'b00, 32'hFFFFFFFF, 1'b1);
      checkOutput("errNoReq", 32'(burstsSeen - bs), 32'd1);

      // Grant never comes: timeout after TIMEOUT request cycles.
      gntAfter = 0;
      respData = 32'h5A5A5A5A;
      applyStimulus(1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 2'b11, 32'h0, 1'b1);
      checkOutput("toBurstLen", 32'(lastBurstLen), 32'd15);
      checkOutput("toLatency", 32'(doneCycle - acceptCycle), 32'd15);

      // Reset during REQ drops the command silently.
      applyStimulus(1'b0, 32'h44, 32'h0, 2'b10, 1'b0, 2'b00, 32'h0, 1'b0);
      dc = doneCount;
      repeat (3) @(negedge clk_i);
      checkOutput("midReqHigh", 32'(req_o), 32'd1);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      checkOutput("rstMidReq", 32'(req_o), 32'd0);
      checkOutput("rstMidReady", 32'(cmd_ready_o), 32'd1);
      @(negedge clk_i);
      rst_i = 1'b0;
      repeat (5) @(negedge clk_i);
      checkOutput("rstNoDone", 32'(doneCount - dc), 32'd0);

      // Back-to-back loads: one request burst each.
      gntAfter = 1;
      respData = 32'h0000007F;
      bs = burstsSeen;
      applyStimulus(1'b0, 32'h80, 32'h0, 2'b00, 1'b0, 2'b00, 32'h0000007F, 1'b1);
      respData = 32'hCAFEF00D;
      applyStimulus(1'b0, 32'h84, 32'h0, 2'b10, 1'b0, 2'b00, 32'hCAFEF00D, 1'b1);
      repeat (2) @(negedge clk_i);
      checkOutput("b2bBursts", 32'(burstsSeen - bs), 32'd2);
      checkOutput("b2bBurstLen", 32'(lastBurstLen), 32'd1);

      checkOutput("sbLeftover", 32'(sbQueue.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
